ora_seq_checker: RTL and testbench

Terminating output-response analyzer for the NoC traffic-generation models: sits at the sink end of a traffic stream and consumes the packets a via/TPG emits. Each packet is unpacked as {src node, dest node, 8-bit source ID, data counter}. The block checks destination, source ID and per-source sequence continuity, and keeps packet and error statistics. It asserts `done` once every tracked source has delivered enough packets, and replaces a free-running sink with a self-checking one.

---
 rtl/ora_seq_checker.sv | 170 +++++++++++++++++
 tb/tb_ora_seq_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ora_seq_checker.sv
// Sink-side output-response analyzer: checks destination, source ID and
// per-source sequence continuity of incoming packets and keeps statistics.
module ora_seq_checker #(
  parameter int i0_WIDTH     = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NUM_SRC      = 4,
  parameter int NODE         = 15,
  parameter int DONE_COUNT   = 100,
  parameter int READY_PERIOD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [i0_WIDTH-1:0] i0_data_in,
  input  logic                i0_valid_in,
  output logic                i0_ready_out,
  output logic                done,
  output logic [31:0]         pkt_count,
  output logic [15:0]         err_count,
  output logic                err_flag,
  output logic [1:0]          last_err_code,
  output logic [7:0]          last_err_id
);

  localparam int A  = N_ADDR_WIDTH;
  localparam int DW = i0_WIDTH - 2*A - 8;
  localparam int CW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  logic [A-1:0]  src_s;
  logic [A-1:0]  dst_s;
  logic [7:0]    id_s;
  logic [DW-1:0] data_s;
  logic          unused_s;

  logic          acc_s;
  logic          dst_ok_s;
  logic          id_ok_s;
  logic [DW-1:0] exp_sel_s;
  logic          seq_err_s;
  logic          err_s;
  logic [1:0]    code_s;
  logic          all_s;

  logic [DW-1:0] exp_q [NUM_SRC];
  logic [DW-1:0] exp_d [NUM_SRC];
  logic [7:0]    rx_q  [NUM_SRC];
  logic [7:0]    rx_d  [NUM_SRC];
  logic [CW-1:0] c_q, c_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [31:0]   pkt_q, pkt_d;
  logic [15:0]   err_q, err_d;
  logic          flag_q, flag_d;
  logic [1:0]    code_q, code_d;
  logic [7:0]    eid_q, eid_d;

  assign src_s    = i0_data_in[i0_WIDTH-1 -: A];
  assign dst_s    = i0_data_in[i0_WIDTH-1-A -: A];
  assign id_s     = i0_data_in[i0_WIDTH-1-2*A -: 8];
  assign data_s   = i0_data_in[DW-1:0];
  // The source node is carried only; it takes no part in checking.
  assign unused_s = ^src_s;

  assign acc_s     = i0_valid_in & ready_q;
  assign dst_ok_s  = (dst_s == A'(NODE));
  assign id_ok_s   = (id_s < 8'(NUM_SRC));
  assign seq_err_s = (data_s != exp_sel_s);
  assign err_s     = acc_s & (~dst_ok_s | ~id_ok_s | seq_err_s);

  // Error classification and expected-value lookup for the current beat.
  always_comb begin
    exp_sel_s = DW'(1);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_s == 8'(i)) begin
        exp_sel_s = exp_q[i];
      end else begin
        exp_sel_s = exp_sel_s;
      end
    end
    case ({dst_ok_s, id_ok_s})
      2'b00, 2'b01: code_s = 2'd1;
      2'b10:        code_s = 2'd2;
      2'b11:        code_s = 2'd3;
      default:      code_s = 2'd0;
    endcase
  end

  // Next-state for per-source tracking, statistics and ready throttle.
  always_comb begin
    all_s = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (acc_s && dst_ok_s && id_ok_s && (id_s == 8'(i))) begin
        exp_d[i] = data_s + DW'(1);
        rx_d[i]  = (rx_q[i] == 8'hFF) ? rx_q[i] : rx_q[i] + 8'd1;
      end else begin
        exp_d[i] = exp_q[i];
        rx_d[i]  = rx_q[i];
      end
      all_s = all_s & (rx_d[i] > 8'(DONE_COUNT));
    end
    done_d = done_q | all_s;

    if (acc_s) begin
      pkt_d = pkt_q + 32'd1;
    end else begin
      pkt_d = pkt_q;
    end

    if (err_s) begin
      err_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
      flag_d = 1'b1;
      code_d = code_s;
      eid_d  = id_s;
    end else begin
      err_d  = err_q;
      flag_d = flag_q;
      code_d = code_q;
      eid_d  = eid_q;
    end

    // Ready drops for one cycle when the phase counter sits at its last value.
    if (READY_PERIOD > 1) begin
      c_d     = (c_q == CW'(READY_PERIOD-1)) ? {CW{1'b0}} : c_q + CW'(1);
      ready_d = (c_q != CW'(READY_PERIOD-1));
    end else begin
      c_d     = {CW{1'b0}};
      ready_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_q[i] <= DW'(1);
        rx_q[i]  <= 8'd0;
      end
      c_q     <= {CW{1'b0}};
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pkt_q   <= 32'd0;
      err_q   <= 16'd0;
      flag_q  <= 1'b0;
      code_q  <= 2'd0;
      eid_q   <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        exp_q[i] <= exp_d[i];
        rx_q[i]  <= rx_d[i];
      end
      c_q     <= c_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      code_q  <= code_d;
      eid_q   <= eid_d;
    end
  end

  assign i0_ready_out  = ready_q;
  assign done          = done_q;
  assign pkt_count     = pkt_q;
  assign err_count     = err_q;
  assign err_flag      = flag_q;
  assign last_err_code = code_q;
  assign last_err_id   = eid_q;

endmodule

// File: tb/tb_ora_seq_checker.sv
// Directed self-checking bench for ora_seq_checker: one always-ready instance
// and one with READY_PERIOD=4 for the backpressure case.
module tb_ora_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'd0;
  logic        valid = 1'b0;
  logic [31:0] data1 = 32'd0;
  logic        valid1 = 1'b0;

  logic        ready, done, eflag;
  logic [31:0] pcnt;
  logic [15:0] ecnt;
  logic [1:0]  ecode;
  logic [7:0]  eid;

  logic        ready1, done1, eflag1;
  logic [31:0] pcnt1;
  logic [15:0] ecnt1;
  logic [1:0]  ecode1;
  logic [7:0]  eid1;

  int n_checks = 0;
  int n_fail   = 0;
  int lows;

  always #5 clk = ~clk;

  ora_seq_checker dut (
    .clk(clk), .rst(rst), .i0_data_in(data), .i0_valid_in(valid),
    .i0_ready_out(ready), .done(done), .pkt_count(pcnt), .err_count(ecnt),
    .err_flag(eflag), .last_err_code(ecode), .last_err_id(eid)
  );

  ora_seq_checker #(.READY_PERIOD(4)) dut_bp (
    .clk(clk), .rst(rst), .i0_data_in(data1), .i0_valid_in(valid1),
    .i0_ready_out(ready1), .done(done1), .pkt_count(pcnt1), .err_count(ecnt1),
    .err_flag(eflag1), .last_err_code(ecode1), .last_err_id(eid1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat presented for exactly one clock edge; returns at the next negedge.
  task automatic beat(input logic [3:0] dst, input logic [7:0] id, input logic [15:0] d);
    valid = 1'b1;
    data  = {4'd2, dst, id, d};
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pkt", pcnt, 32'd0);
    check("rst_err", {16'd0, ecnt}, 32'd0);
    check("rst_flag", {31'd0, eflag}, 32'd0);
    check("rst_code", {30'd0, ecode}, 32'd0);
    check("rst_eid", {24'd0, eid}, 32'd0);

    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", {31'd0, ready}, 32'd1);

    // Destination mismatch leaves exp[0] at 1.
    beat(4'd3, 8'd0, 16'd1);
    check("dst_err", {16'd0, ecnt}, 32'd1);
    check("dst_code", {30'd0, ecode}, 32'd1);
    check("dst_eid", {24'd0, eid}, 32'd0);
    check("dst_flag", {31'd0, eflag}, 32'd1);
    beat(4'd15, 8'd0, 16'd1);
    check("dst_noseq", {16'd0, ecnt}, 32'd1);
    check("pkt2", pcnt, 32'd2);

    beat(4'd15, 8'd7, 16'd5);
    check("id_err", {16'd0, ecnt}, 32'd2);
    check("id_code", {30'd0, ecode}, 32'd2);
    check("id_eid", {24'd0, eid}, 32'd7);

    beat(4'd15, 8'd1, 16'd1);
    beat(4'd15, 8'd1, 16'd2);
    beat(4'd15, 8'd1, 16'd5);
    check("seq_err", {16'd0, ecnt}, 32'd3);
    check("seq_code", {30'd0, ecode}, 32'd3);
    check("seq_eid", {24'd0, eid}, 32'd1);
    beat(4'd15, 8'd1, 16'd6);
    check("seq_resync", {16'd0, ecnt}, 32'd3);
    beat(4'd15, 8'd0, 16'd2);
    check("other_src_ok", {16'd0, ecnt}, 32'd3);
    beat(4'd15, 8'd2, 16'd1);
    beat(4'd15, 8'd2, 16'd2);
    check("pkt10", pcnt, 32'd10);

    // Reset mid-stream with a beat presented; it must be dropped.
    rst   = 1'b1;
    valid = 1'b1;
    data  = {4'd2, 4'd15, 8'd0, 16'd1};
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_pkt", pcnt, 32'd0);
    check("mid_rst_err", {16'd0, ecnt}, 32'd0);
    check("mid_rst_code", {30'd0, ecode}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    beat(4'd15, 8'd0, 16'd1);
    check("post_rst_pkt", pcnt, 32'd1);
    check("post_rst_err", {16'd0, ecnt}, 32'd0);
    check("post_rst_flag", {31'd0, eflag}, 32'd0);

    // Full round-robin stream.
    do_reset();
    for (int d = 1; d <= 102; d++) begin
      for (int id = 0; id < 4; id++) begin
        beat(4'd15, 8'(id), 16'(d));
        if (d == 101 && id == 2) check("done_early", {31'd0, done}, 32'd0);
        if (d == 101 && id == 3) check("done_rise", {31'd0, done}, 32'd1);
      end
    end
    check("stream_pkt", pcnt, 32'd408);
    check("stream_err", {16'd0, ecnt}, 32'd0);

    // exp[0]=103; FFFF is an error and resyncs, then 0 is a legal wrap.
    beat(4'd15, 8'd0, 16'hFFFF);
    check("wrap_pre_err", {16'd0, ecnt}, 32'd1);
    beat(4'd15, 8'd0, 16'h0000);
    check("wrap_ok", {16'd0, ecnt}, 32'd1);
    check("done_sticky", {31'd0, done}, 32'd1);

    // Backpressure instance: valid held for 16 edges.
    lows   = 0;
    valid1 = 1'b1;
    data1  = {4'd2, 4'd3, 8'd0, 16'd1};
    for (int i = 0; i < 16; i++) begin
      if (!ready1) lows++;
      @(posedge clk);
      @(negedge clk);
    end
    valid1 = 1'b0;
    check("bp_ready_lows", lows, 32'd4);
    check("bp_pkt", pcnt1, 32'd12);
    check("bp_err", {16'd0, ecnt1}, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
